// File: rtl/jt053244_pkg.sv
// Shared types and constants for the 053244 sprite row drawer.
// Holds the FSM state encoding, the tile geometry and the line-buffer pixel layout.
package jt053244_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH0 = 2'd1,
        FETCH1 = 2'd2,
        DRAW   = 2'd3
    } state_t;

    localparam int ZUNIT    = 64;
    localparam int TILE_W   = 16;
    localparam int TILE_POS = 1024;
    localparam int MAX_OUT  = 512;

    typedef struct packed {
        logic       shd;
        logic [6:0] attr;
        logic [3:0] pix;
    } buf_pix_t;

    // Pixel n of a row: word0 carries 0-7, word1 carries 8-15, leftmost pixel in the top nibble.
    function automatic logic [3:0] row_pix(input logic [31:0] w0, input logic [31:0] w1,
                                           input logic [3:0] n);
        logic [31:0] w;
        w = n[3] ? w1 : w0;
        return w[{~n[2:0], 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/jt053244_draw_if.sv
// Request, ROM and line-buffer signals of the sprite row drawer.
// The scan/memory side uses master; the drawer uses slave.
interface jt053244_draw_if #(
    parameter int BUF_AW = 9
);
    logic              dr_start;
    logic              dr_busy;
    logic [15:0]       code;
    logic [6:0]        attr;
    logic              shd;
    logic              hflip;
    logic [9:0]        hpos;
    logic [3:0]        ysub;
    logic [11:0]       hzoom;
    logic              hz_keep;
    logic              rom_cs;
    logic [20:0]       rom_addr;
    logic [31:0]       rom_data;
    logic              rom_ok;
    logic              buf_we;
    logic [BUF_AW-1:0] buf_addr;
    logic [11:0]       buf_din;

    modport master (
        output dr_start, code, attr, shd, hflip, hpos, ysub, hzoom, hz_keep, rom_data, rom_ok,
        input  dr_busy, rom_cs, rom_addr, buf_we, buf_addr, buf_din
    );

    modport slave (
        input  dr_start, code, attr, shd, hflip, hpos, ysub, hzoom, hz_keep, rom_data, rom_ok,
        output dr_busy, rom_cs, rom_addr, buf_we, buf_addr, buf_din
    );
endinterface

// File: rtl/jt053244_hzacc.sv
// Horizontal accumulator: output x, source position with fraction, tile-end detect.
// Latency: x/pos update on the cycle after adv; last is combinational from current pos.
// Backpressure: none, advances only when adv is high.
module jt053244_hzacc
    import jt053244_pkg::*;
#(
    parameter int UNIT = 64
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        keep,
    input  logic [9:0]  hpos,
    input  logic        adv,
    input  logic [11:0] step,
    output logic [9:0]  x,
    output logic [3:0]  idx,
    output logic        last
);
    localparam int             SH   = $clog2(UNIT);
    localparam logic [13:0]    TILE = 14'(TILE_W * UNIT);
    localparam logic [8:0]     CAP  = 9'(MAX_OUT - 1);

    logic [12:0] pos;
    logic [8:0]  cnt;
    logic [13:0] sum;
    logic        tile_end;

    assign sum      = {1'b0, pos} + {2'b00, step};
    assign tile_end = (sum >= TILE);
    assign last     = tile_end || (cnt == CAP);
    assign idx      = 4'(pos >> SH);

    always_ff @(posedge clk) begin
        if (rst) begin
            x   <= '0;
            pos <= '0;
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
            if (!keep) begin
                x   <= hpos;
                pos <= '0;
            end
        end else if (adv) begin
            x   <= x + 10'd1;
            cnt <= cnt + 9'd1;
            // The leftover fraction past the tile edge seeds the next tile when keep is used.
            pos <= tile_end ? 13'(sum - TILE) : sum[12:0];
        end
    end

endmodule

// File: rtl/jt053244_draw.sv
// Sprite row drawer: fetches a 16-pixel 4bpp row, applies hzoom/hflip, writes opaque pixels.
// Latency: first line-buffer write 4 cycles after dr_start with no ROM wait, then 1 pixel/cycle.
// Backpressure: ROM fetches stall until rom_ok; dr_start is ignored while dr_busy is high.
module jt053244_draw #(
    parameter int BUF_AW = 9,
    parameter int ZUNIT  = 64
)(
    input  logic           clk,
    input  logic           rst,
    jt053244_draw_if.slave bus
);
    import jt053244_pkg::*;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              rom_cs_q, rom_cs_d;
    logic [20:0]       rom_addr_q, rom_addr_d;
    logic              buf_we_q, buf_we_d;
    logic [BUF_AW-1:0] buf_addr_q, buf_addr_d;
    buf_pix_t          buf_din_q, buf_din_d;

    logic [15:0] code_q;
    logic [6:0]  attr_q;
    logic        shd_q;
    logic        hflip_q;
    logic [3:0]  ysub_q;
    logic [11:0] step_q;
    logic [31:0] w0_q, w1_q;

    logic       accept, ld_w0, ld_w1, adv, last;
    logic [9:0] x;
    logic [3:0] idx;
    logic [3:0] pix;

    assign accept = (state_q == IDLE) && bus.dr_start && !busy_q;
    assign pix    = row_pix(w0_q, w1_q, hflip_q ? ~idx : idx);

    jt053244_hzacc #(.UNIT(ZUNIT)) u_hzacc (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .keep  (bus.hz_keep),
        .hpos  (bus.hpos),
        .adv   (adv),
        .step  (step_q),
        .x     (x),
        .idx   (idx),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            buf_we_q   <= 1'b0;
            buf_addr_q <= '0;
            buf_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            rom_cs_q   <= rom_cs_d;
            rom_addr_q <= rom_addr_d;
            buf_we_q   <= buf_we_d;
            buf_addr_q <= buf_addr_d;
            buf_din_q  <= buf_din_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        // Busy also covers the cycle after DRAW so the final registered write lands inside it.
        busy_d     = accept || (state_q != IDLE);
        rom_cs_d   = rom_cs_q;
        rom_addr_d = rom_addr_q;
        buf_we_d   = 1'b0;
        buf_addr_d = buf_addr_q;
        buf_din_d  = buf_din_q;
        ld_w0      = 1'b0;
        ld_w1      = 1'b0;
        adv        = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = FETCH0;
                    rom_cs_d   = 1'b1;
                    rom_addr_d = {bus.code, bus.ysub, 1'b0};
                end
            end
            FETCH0: begin
                if (bus.rom_ok) begin
                    ld_w0      = 1'b1;
                    rom_addr_d = {code_q, ysub_q, 1'b1};
                    state_d    = FETCH1;
                end
            end
            FETCH1: begin
                if (bus.rom_ok) begin
                    ld_w1    = 1'b1;
                    rom_cs_d = 1'b0;
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                adv        = 1'b1;
                buf_we_d   = (pix != 4'd0) && (x[9:BUF_AW] == '0);
                buf_addr_d = x[BUF_AW-1:0];
                buf_din_d  = '{shd: shd_q, attr: attr_q, pix: pix};
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q  <= '0;
            attr_q  <= '0;
            shd_q   <= 1'b0;
            hflip_q <= 1'b0;
            ysub_q  <= '0;
            step_q  <= '0;
            w0_q    <= '0;
            w1_q    <= '0;
        end else begin
            if (accept) begin
                code_q  <= bus.code;
                attr_q  <= bus.attr;
                shd_q   <= bus.shd;
                hflip_q <= bus.hflip;
                ysub_q  <= bus.ysub;
                step_q  <= (bus.hzoom == 12'd0) ? 12'd1 : bus.hzoom;
            end
            if (ld_w0) w0_q <= bus.rom_data;
            if (ld_w1) w1_q <= bus.rom_data;
        end
    end

    assign bus.dr_busy  = busy_q;
    assign bus.rom_cs   = rom_cs_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.buf_we   = buf_we_q;
    assign bus.buf_addr = buf_addr_q;
    assign bus.buf_din  = buf_din_q;

endmodule

// File: tb/tb_jt053244_draw.sv
// Bench for jt053244_draw: a pixel-level row model feeds a write scoreboard,
// plus literal expectations for counts, addresses and handshake timing.
module tb_jt053244_draw;

    typedef struct packed {
        logic [8:0]  addr;
        logic [11:0] din;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jt053244_draw_if #(.BUF_AW(9)) bus ();

    jt053244_draw #(.BUF_AW(9), .ZUNIT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]  row [16];
    logic [31:0] w0, w1;
    wr_t         exp_q [$];
    int          mx = 0, mpos = 0;

    // ROM returns garbage unless rom_ok, so an early latch shows up as wrong pixels.
    assign bus.rom_data = !bus.rom_ok ? 32'hA5A5A5A5 : (bus.rom_addr[0] ? w1 : w0);

    int          req_cyc, first_we_cyc, busy_cnt, wr_cnt, half;
    logic [19:0] cur_tag;
    logic [8:0]  first_addr, last_addr;
    logic [11:0] first_din;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            if (bus.dr_start && !bus.dr_busy) begin
                req_cyc      = cyc;
                half         = 0;
                cur_tag      = {bus.code, bus.ysub};
                busy_cnt     = 0;
                wr_cnt       = 0;
                first_we_cyc = -1;
            end
            if (bus.dr_busy) busy_cnt++;
            if (bus.rom_cs) begin
                chk("rom_addr", {11'd0, bus.rom_addr}, {11'd0, cur_tag, half[0]});
                if (bus.rom_ok) half++;
            end
            if (bus.buf_we) begin
                if (first_we_cyc < 0) begin
                    first_we_cyc = cyc;
                    first_addr   = bus.buf_addr;
                    first_din    = bus.buf_din;
                end
                last_addr = bus.buf_addr;
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h din %0h, expected no write",
                             bus.buf_addr, bus.buf_din);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {23'd0, bus.buf_addr}, {23'd0, e.addr});
                    chk("wr_din", {20'd0, bus.buf_din}, {20'd0, e.din});
                end
            end
        end
    end

    // Model: output k samples source (pos0 + k*step)/64 and lands at x0 + k.
    task automatic issue(input logic [9:0] hp, input logic [11:0] hz, input logic keep,
                         input logic fl, input logic [6:0] at, input logic sh,
                         input logic [15:0] cd, input logic [3:0] ys);
        int step, x0, p0, n, pe, p, src, xx;
        logic [3:0] px;
        step = (hz == 0) ? 1 : int'(hz);
        x0   = keep ? mx : int'(hp);
        p0   = keep ? mpos : 0;
        n    = (p0 >= 1024) ? 1 : (1024 - p0 + step - 1) / step;
        if (n > 512) n = 512;
        for (int k = 0; k < n; k++) begin
            p   = p0 + k * step;
            src = (p / 64) % 16;
            if (fl) src = 15 - src;
            px  = row[src];
            xx  = (x0 + k) % 1024;
            if (px != 4'd0 && xx < 512) exp_q.push_back(wr_t'{addr: 9'(xx), din: {sh, at, px}});
        end
        pe   = p0 + n * step;
        mpos = (pe >= 1024) ? pe - 1024 : pe;
        mx   = (x0 + n) % 1024;
        @(posedge clk); #1;
        bus.hpos = hp; bus.hzoom = hz; bus.hz_keep = keep; bus.hflip = fl;
        bus.attr = at; bus.shd = sh; bus.code = cd; bus.ysub = ys;
        bus.dr_start = 1'b1;
        @(posedge clk); #1;
        bus.dr_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!bus.dr_busy) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: dr_busy still 1 after 1000 cycles, expected 0", tag);
        end
    endtask

    task automatic post(input string tag, input int exp_wr, input int exp_busy, input int exp_lat);
        chk({tag, "_writes"}, wr_cnt, exp_wr);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        chk({tag, "_latency"}, first_we_cyc - req_cyc, exp_lat);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) row[i] = 4'((i + 1) % 16);
        w0 = '0;
        w1 = '0;
        for (int i = 0; i < 8; i++) begin
            w0 = {w0[27:0], row[i]};
            w1 = {w1[27:0], row[i + 8]};
        end
        bus.dr_start = 0; bus.code = 0; bus.attr = 0; bus.shd = 0; bus.hflip = 0;
        bus.hpos = 0; bus.ysub = 0; bus.hzoom = 0; bus.hz_keep = 0; bus.rom_ok = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dr_busy", bus.dr_busy, 0);
        chk("rst_rom_cs", bus.rom_cs, 0);
        chk("rst_rom_addr", bus.rom_addr, 0);
        chk("rst_buf_we", bus.buf_we, 0);
        chk("rst_buf_addr", bus.buf_addr, 0);
        chk("rst_buf_din", bus.buf_din, 0);
        @(posedge clk); #1 rst = 0;

        // 1:1 draw
        issue(10'h020, 12'h040, 0, 0, 7'h2A, 0, 16'h1234, 4'h3);
        wait_idle("t1");
        post("t1", 15, 19, 4);
        chk("t1_first_addr", first_addr, 9'h020);
        chk("t1_first_din", first_din, {1'b0, 7'h2A, 4'h1});
        chk("t1_last_addr", last_addr, 9'h02E);

        // hflip
        issue(10'h020, 12'h040, 0, 1, 7'h2A, 1, 16'hBEEF, 4'hC);
        wait_idle("t2");
        post("t2", 15, 19, 5);
        chk("t2_first_addr", first_addr, 9'h021);
        chk("t2_first_din", first_din, {1'b1, 7'h2A, 4'hF});
        chk("t2_last_addr", last_addr, 9'h02F);

        // reduce 2:1 and enlarge 1:2
        issue(10'h040, 12'h080, 0, 0, 7'h11, 0, 16'h0001, 4'h0);
        wait_idle("t3");
        post("t3", 8, 11, 4);
        issue(10'h040, 12'h020, 0, 0, 7'h12, 0, 16'h0002, 4'h1);
        wait_idle("t4");
        post("t4", 30, 35, 4);

        // 0x30 step, then continuation with kept x and fraction
        issue(10'h100, 12'h030, 0, 0, 7'h33, 0, 16'h0003, 4'h2);
        chk("t5_model_pos", mpos, 32);
        chk("t5_model_x", mx, 10'h116);
        wait_idle("t5");
        post("t5", 20, 25, 4);
        issue(10'h3FF, 12'h030, 1, 0, 7'h34, 0, 16'h0004, 4'h2);
        wait_idle("t6");
        post("t6", 20, 24, 4);
        chk("t6_first_addr", first_addr, 9'h116);

        // right edge of the line buffer
        issue(10'h1FC, 12'h040, 0, 0, 7'h55, 0, 16'h0005, 4'h7);
        wait_idle("t7");
        post("t7", 4, 19, 4);
        chk("t7_last_addr", last_addr, 9'h1FF);

        // ROM wait states
        bus.rom_ok = 0;
        issue(10'h040, 12'h040, 0, 0, 7'h66, 1, 16'h0ABC, 4'h9);
        repeat (5) @(posedge clk);
        #1 bus.rom_ok = 1;
        wait_idle("t8");
        post("t8", 15, 24, 9);

        // dr_start during busy is ignored
        issue(10'h060, 12'h040, 0, 0, 7'h0F, 0, 16'h0777, 4'h4);
        repeat (6) @(posedge clk);
        #1;
        bus.code = 16'hFFFF; bus.attr = 7'h00; bus.hpos = 10'h300; bus.hflip = 1;
        bus.dr_start = 1;
        @(posedge clk); #1 bus.dr_start = 0;
        wait_idle("t9");
        post("t9", 15, 19, 4);
        repeat (4) @(negedge clk);
        chk("t9_idle_rom_cs", bus.rom_cs, 0);
        chk("t9_idle_busy", bus.dr_busy, 0);

        // reset in the middle of DRAW, then a fresh request
        issue(10'h090, 12'h040, 0, 0, 7'h44, 0, 16'h0888, 4'h5);
        repeat (8) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        exp_q.delete();
        mx = 0;
        mpos = 0;
        @(negedge clk);
        chk("t10_rst_buf_we", bus.buf_we, 0);
        chk("t10_rst_busy", bus.dr_busy, 0);
        issue(10'h080, 12'h040, 0, 0, 7'h45, 0, 16'h0999, 4'h6);
        wait_idle("t11");
        post("t11", 15, 19, 4);
        chk("t11_first_addr", first_addr, 9'h080);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
